// File: rtl/fp_norm_round_pkg.sv
// fp_norm_round shared types and widths for the FP adder post-add stage.
// Holds format parameters and the stage-1 / stage-2 pipeline bundles.
package fp_norm_round_pkg;

    localparam int SIG_WIDTH = 23;
    localparam int EXP_WIDTH = 8;
    localparam int SW        = 2 * SIG_WIDTH + 3;
    localparam int EXP_MAX   = (1 << EXP_WIDTH) - 1;
    localparam int BIAS      = 127;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Normalized mantissa width (carry bit dropped) and signed exponent width
    localparam int MW = SW - 1;
    localparam int EW = EXP_WIDTH + 2;

    typedef struct packed {
        logic [MW-1:0]        mant;
        logic                 sticky;
        logic signed [EW-1:0] exp;
        logic                 zero;
        logic                 sign;
        logic                 special;
        logic [31:0]          sval;
    } s1_t;

    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
        logic        unf;
    } s2_t;

endpackage

// File: rtl/fp_norm_round_if.sv
// Handshake bundle between lod, fp_norm_round and the result consumer.
// master: upstream/downstream environment; slave: the fp_norm_round stage.
interface fp_norm_round_if;
    import fp_norm_round_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [SW-1:0]        in_sum;
    logic [5:0]           in_norm_amt;
    logic                 in_right_shift;
    logic [EXP_WIDTH-1:0] in_exp;
    logic                 in_sign;
    logic                 in_special;
    logic [31:0]          in_special_val;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_result;
    logic                 out_overflow;
    logic                 out_underflow;

    modport master (
        output in_valid, in_sum, in_norm_amt, in_right_shift,
        output in_exp, in_sign, in_special, in_special_val,
        output out_ready,
        input  in_ready, out_valid, out_result,
        input  out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sum, in_norm_amt, in_right_shift,
        input  in_exp, in_sign, in_special, in_special_val,
        input  out_ready,
        output in_ready, out_valid, out_result,
        output out_overflow, out_underflow
    );

endinterface

// File: rtl/fp_norm_round_rne.sv
// fp_round_rne: round-to-nearest-even on a 24-bit mantissa with G/R/S.
// Ports: mant_i (hidden+fraction), g_i, r_i, s_i -> frac_o, carry_o.
module fp_round_rne
    import fp_norm_round_pkg::*;
(
    input  logic [SIG_WIDTH:0]   mant_i,
    input  logic                 g_i,
    input  logic                 r_i,
    input  logic                 s_i,
    output logic [SIG_WIDTH-1:0] frac_o,
    output logic                 carry_o
);

    logic                 up;
    logic [SIG_WIDTH+1:0] sum;

    assign up     = g_i & (r_i | s_i | mant_i[0]);
    assign sum    = {1'b0, mant_i} + {{(SIG_WIDTH + 1){1'b0}}, up};
    assign frac_o = sum[SIG_WIDTH-1:0];
    // Fraction overflowed iff the bits above it no longer match the input
    assign carry_o = sum[SIG_WIDTH+1:SIG_WIDTH] != {1'b0, mant_i[SIG_WIDTH]};

endmodule

// File: rtl/fp_norm_round.sv
// fp_norm_round: two-stage normalize / RNE round / pack of an FP add sum.
// Ports: clk, rst_n (async active-low), bus (fp_norm_round_if.slave).
module fp_norm_round
    import fp_norm_round_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    fp_norm_round_if.slave bus
);

    localparam logic signed [EW-1:0] EMAX_S = EW'(EXP_MAX);
    localparam logic signed [EW-1:0] EZERO  = '0;

    logic s1_valid_q;
    logic out_valid_q;
    s1_t  s1_d;
    s1_t  s1_q;
    s2_t  out_d;
    s2_t  out_q;

    logic s1_adv;
    logic s2_adv;

    assign s2_adv       = !out_valid_q | bus.out_ready;
    assign s1_adv       = !s1_valid_q | s2_adv;
    assign bus.in_ready = s1_adv;

    // Stage 1: normalize
    logic [MW-1:0] mant_l;

    assign mant_l = bus.in_sum[MW-1:0] << bus.in_norm_amt;

    always_comb begin
        s1_d         = '0;
        s1_d.zero    = bus.in_sum == '0;
        s1_d.sign    = bus.in_sign;
        s1_d.special = bus.in_special;
        s1_d.sval    = bus.in_special_val;
        if (bus.in_right_shift) begin
            s1_d.mant   = bus.in_sum[SW-1:1];
            s1_d.sticky = bus.in_sum[0];
            s1_d.exp    = {{(EW - EXP_WIDTH){1'b0}}, bus.in_exp} + EW'(1);
        end else begin
            s1_d.mant   = mant_l;
            s1_d.sticky = 1'b0;
            s1_d.exp    = {{(EW - EXP_WIDTH){1'b0}}, bus.in_exp}
                        - {{(EW - 6){1'b0}}, bus.in_norm_amt};
        end
    end

    // Stage 2: round and pack
    logic [SIG_WIDTH-1:0] frac;
    logic                 carry;
    logic                 sticky;
    logic signed [EW-1:0] exp_r;

    assign sticky = (|s1_q.mant[MW-SIG_WIDTH-4:0]) | s1_q.sticky;

    fp_round_rne u_rne (
        .mant_i  (s1_q.mant[MW-1:MW-SIG_WIDTH-1]),
        .g_i     (s1_q.mant[MW-SIG_WIDTH-2]),
        .r_i     (s1_q.mant[MW-SIG_WIDTH-3]),
        .s_i     (sticky),
        .frac_o  (frac),
        .carry_o (carry)
    );

    assign exp_r = s1_q.exp + {{(EW - 1){1'b0}}, carry};

    always_comb begin
        out_d = '0;
        if (s1_q.special) begin
            out_d.result = s1_q.sval;
        end else if (s1_q.zero) begin
            out_d.result = '0;
        end else if (exp_r >= EMAX_S) begin
            out_d.result = {s1_q.sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
            out_d.ovf    = 1'b1;
        end else if (exp_r <= EZERO) begin
            out_d.result = {s1_q.sign, {(EXP_WIDTH + SIG_WIDTH){1'b0}}};
            out_d.unf    = 1'b1;
        end else begin
            out_d.result = {s1_q.sign, exp_r[EXP_WIDTH-1:0], frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
            end
            if (s1_adv && bus.in_valid) begin
                s1_q <= s1_d;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
            end
            if (s2_adv && s1_valid_q) begin
                out_q <= out_d;
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = out_q.result;
    assign bus.out_overflow  = out_q.ovf;
    assign bus.out_underflow = out_q.unf;

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Post-add normalize/round/pack stage of the 32-bit FP adder.
- Sits directly downstream of the leading-one detector (lod). Consumes the raw 49-bit significand sum, the lod shift amount and the right-shift flag, plus the pre-add exponent and sign.
- Normalizes the sum, applies round-to-nearest-even, handles exponent overflow/underflow and IEEE special bypass, and emits a packed single-precision word.
- Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- SIG_WIDTH, 23, stored fraction width; sum width SW = 2*SIG_WIDTH+3 = 49.
- EXP_WIDTH, 8, biased exponent width; EXP_MAX = 2^EXP_WIDTH-1 = 255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_sum  in  SW  unsigned significand sum; bit SW-1 is carry, bit SW-2 is hidden-one position
- in_norm_amt  in  6  lod left-shift count (1 when carry set)
- in_right_shift  in  1  lod carry flag (= in_sum[SW-1])
- in_exp  in  EXP_WIDTH  biased exponent of larger operand
- in_sign  in  1  result sign
- in_special  in  1  result is NaN/Inf/forced value from the operand classifier
- in_special_val  in  32  packed value used when in_special=1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  32  packed IEEE-754 single {sign, exp, fraction}
- out_overflow  out  1  result saturated to Inf
- out_underflow  out  1  result flushed to zero

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_overflow=0, out_underflow=0. All pipeline data registers clear. Any in-flight beat is dropped. in_ready=1 immediately after release.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational).
  - A beat transfers on a valid&ready cycle.
  - out_result/out_valid are held stable while out_valid & !out_ready.
  - Throughput is 1 beat/cycle. Latency is 2 cycles from accept to out_valid when unstalled.
- Stage 1 (normalize), registered on accept:
  - If right_shift: mant = in_sum >> 1, with sticky capturing in_sum[0]; exp10 = in_exp + 1.
  - Else: mant = in_sum << in_norm_amt (truncated to SW bits); exp10 = in_exp - in_norm_amt.
  - exp10 is a 10-bit signed value.
  - zero = (in_sum == 0).
- Stage 2 (round/pack):
  - Normalized mant: bit47 = hidden one, bits46:24 = fraction, G = bit23, R = bit22, S = |bits21:0 | shift sticky.
  - Round up iff G & (R | S | fraction LSB).
  - Fraction+1 carry-out: fraction = 0, exp10 += 1.
- Result select, in priority order:
  1. in_special → in_special_val; flags 0.
  2. zero → 0x00000000 (+0); flags 0.
  3. exp10 ≥ 255 → {sign, 8'hFF, 0}; out_overflow = 1.
  4. exp10 ≤ 0 → {sign, 31'b0}; out_underflow = 1. No subnormal output.
  5. Otherwise → {sign, exp10[7:0], fraction}.
- Overflow/underflow checks are evaluated after the rounding carry.
- in_norm_amt > 47 with nonzero sum cannot occur from lod and is not checked.
- Simultaneous accept and emit in the same cycle is legal, with no bubble.

Decomposition:
- Shared package (parameters.v include): SIG_WIDTH, EXP_WIDTH, SW, EXP_MAX, BIAS=127, QNAN=32'h7FC00000.
- One natural sub-module: fp_round_rne. Combinational; takes 24-bit mantissa, G, R, S; returns rounded fraction and carry-out. Instantiated in stage 2.

Test Plan:
- 1.0+1.0: in_sum = 1<<48, right_shift=1, amt=1, exp=127, sign=0 → out_result 0x40000000, 2 cycles after accept.
- Tie-even: in_sum = (1<<47)|(1<<23), amt=0, exp=127 → 0x3F800000. Same with bit24 also set → 0x3F800002.
- Round carry: in_sum bits47:23 all ones, rest 0, exp=127 → 0x40000000.
- Overflow/underflow:
  - right_shift=1, exp=254, sign=1 → 0xFF800000, out_overflow=1.
  - in_sum = 1<<42, amt=5, exp=3 → 0x00000000, out_underflow=1.
- Zero/special:
  - in_sum = 0, sign=1 → 0x00000000.
  - in_special=1, in_special_val=0x7FC00000 → 0x7FC00000 regardless of sum.
- Backpressure/reset:
  - Stream 4 beats with out_ready low for 3 cycles → in_ready drops after 2 buffered beats; all 4 results emitted in order, no loss or duplication.
  - Assert rst_n low mid-stream → out_valid=0 immediately; no stale output after release.
